// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - I2C target bus and byte-stream signal bundle
// master: initiator/host side, slave: the i2c_target block.
interface i2c_target_if;
  logic       SCL;
  logic       SDA_IN;
  logic       SDA_OUT;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       addressed;
  logic       start_det;
  logic       stop_det;

  modport slave (
    input  SCL, SDA_IN, tx_data,
    output SDA_OUT, rx_data, rx_valid, rx_first, tx_req, addressed, start_det, stop_det
  );

  modport master (
    output SCL, SDA_IN, tx_data,
    input  SDA_OUT, rx_data, rx_valid, rx_first, tx_req, addressed, start_det, stop_det
  );
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with 7-bit address, write strobes and read byte requests
// Optional: I2C_TARGET_GENERAL_CALL_EN also accepts the general call write address 8'h00.
module i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         n_reset,
  i2c_target_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic                   rw_q, rw_d;
  logic                   phase_q, phase_d;
  logic                   first_q, first_d;
  logic                   rx_pend_q, rx_pend_d;
  logic                   rx_pend_first_q, rx_pend_first_d;
  logic                   sda_out_q, sda_out_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_first_q, rx_first_d;
  logic                   tx_req_q, tx_req_d;
  logic                   addressed_q, addressed_d;
  logic                   start_det_q, start_det_d;
  logic                   stop_det_q, stop_det_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic [7:0] shift_in;
  logic       addr_match;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign sda_rise = sda_s & ~sda_prev_q;
  assign sda_fall = ~sda_s & sda_prev_q;
  assign shift_in = {shift_q[6:0], sda_s};

`ifdef I2C_TARGET_GENERAL_CALL_EN
  assign addr_match = (shift_in[7:1] == ADDRESS) || (shift_in == 8'h00);
`else
  assign addr_match = (shift_in[7:1] == ADDRESS);
`endif

  always_comb begin
    scl_sync_d      = {scl_sync_q[SYNC_STAGES-2:0], bus.SCL};
    sda_sync_d      = {sda_sync_q[SYNC_STAGES-2:0], bus.SDA_IN};
    scl_prev_d      = scl_s;
    sda_prev_d      = sda_s;
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    tx_shift_d      = tx_shift_q;
    rw_d            = rw_q;
    phase_d         = phase_q;
    first_d         = first_q;
    rx_pend_d       = 1'b0;
    rx_pend_first_d = rx_pend_first_q;
    sda_out_d       = sda_out_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_pend_q;
    rx_first_d      = rx_pend_q & rx_pend_first_q;
    tx_req_d        = 1'b0;
    addressed_d     = addressed_q;
    start_det_d     = 1'b0;
    stop_det_d      = 1'b0;

    // Bus conditions override any bit-level activity seen in the same clk.
    if (sda_fall && scl_s) begin
      state_d     = S_ADDR;
      bit_cnt_d   = 3'd0;
      start_det_d = 1'b1;
      addressed_d = 1'b0;
      sda_out_d   = 1'b1;
      phase_d     = 1'b0;
    end else if (sda_rise && scl_s) begin
      state_d     = S_IDLE;
      stop_det_d  = 1'b1;
      addressed_d = 1'b0;
      sda_out_d   = 1'b1;
      phase_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d    = shift_in[0];
            phase_d = 1'b0;
            state_d = addr_match ? S_ADDR_ACK : S_IGNORE;
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_out_d   = 1'b0;
            addressed_d = 1'b1;
            tx_req_d    = rw_q;
            phase_d     = 1'b1;
          end else begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              state_d   = S_READ;
              sda_out_d = tx_shift_q[7];
            end else begin
              state_d   = S_WRITE;
              sda_out_d = 1'b1;
              first_d   = 1'b1;
            end
          end
        end
        S_WRITE: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d       = shift_in;
            rx_pend_d       = 1'b1;
            rx_pend_first_d = first_q;
            first_d         = 1'b0;
            phase_d         = 1'b0;
            state_d         = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_out_d = 1'b0;
            phase_d   = 1'b1;
          end else begin
            sda_out_d = 1'b1;
            phase_d   = 1'b0;
            state_d   = S_WRITE;
          end
        end
        S_READ: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_out_d = 1'b1;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            state_d   = S_READ_ACK;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            sda_out_d  = tx_shift_q[6];
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
        end
        S_READ_ACK: begin
          // phase_q marks an ACK already seen; the next byte starts on the following fall.
          if (scl_rise && !phase_q) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              state_d = S_IGNORE;
            end
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            sda_out_d = tx_shift_q[7];
            state_d   = S_READ;
          end
        end
        S_IGNORE: sda_out_d = 1'b1;
        default:  state_d = S_IDLE;
      endcase
    end

    if (tx_req_q) begin
      tx_shift_d = bus.tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q         <= S_IDLE;
      scl_sync_q      <= '1;
      sda_sync_q      <= '1;
      scl_prev_q      <= 1'b1;
      sda_prev_q      <= 1'b1;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 8'h00;
      tx_shift_q      <= 8'h00;
      rw_q            <= 1'b0;
      phase_q         <= 1'b0;
      first_q         <= 1'b0;
      rx_pend_q       <= 1'b0;
      rx_pend_first_q <= 1'b0;
      sda_out_q       <= 1'b1;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      rx_first_q      <= 1'b0;
      tx_req_q        <= 1'b0;
      addressed_q     <= 1'b0;
      start_det_q     <= 1'b0;
      stop_det_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      scl_sync_q      <= scl_sync_d;
      sda_sync_q      <= sda_sync_d;
      scl_prev_q      <= scl_prev_d;
      sda_prev_q      <= sda_prev_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      tx_shift_q      <= tx_shift_d;
      rw_q            <= rw_d;
      phase_q         <= phase_d;
      first_q         <= first_d;
      rx_pend_q       <= rx_pend_d;
      rx_pend_first_q <= rx_pend_first_d;
      sda_out_q       <= sda_out_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_first_q      <= rx_first_d;
      tx_req_q        <= tx_req_d;
      addressed_q     <= addressed_d;
      start_det_q     <= start_det_d;
      stop_det_q      <= stop_det_d;
    end
  end

  assign bus.SDA_OUT   = sda_out_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_first  = rx_first_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.addressed = addressed_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized bench for i2c_target against a transaction-level model
// Honours I2C_TARGET_GENERAL_CALL_EN when expecting general call behaviour.
module tb_i2c_target;

  localparam logic [6:0] ADDR = 7'h3C;
`ifdef I2C_TARGET_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_reset;
  logic       scl_m, sda_m;
  logic [7:0] tx_data_m;

  always #5 clk = ~clk;

  i2c_target_if bus ();
  assign bus.SCL     = scl_m;
  assign bus.SDA_IN  = sda_m & bus.SDA_OUT;
  assign bus.tx_data = tx_data_m;

  i2c_target #(.ADDRESS(ADDR), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Observed activity and model expectations for the transaction in progress.
  logic       mon_en = 1'b0;
  logic [8:0] rx_got[$];
  logic [8:0] exp_rx[$];
  logic [7:0] tx_q[$];
  int         start_cnt, stop_cnt, txreq_cnt, exp_start, exp_txreq;
  logic       addr_seen, sda_low_seen, exp_addr;
  logic [7:0] data_a[4];

  always @(negedge clk) begin
    if (n_reset && mon_en) begin
      if (bus.rx_valid) rx_got.push_back({bus.rx_first, bus.rx_data});
      if (bus.start_det) start_cnt++;
      if (bus.stop_det) stop_cnt++;
      if (bus.addressed) addr_seen = 1'b1;
      if (!bus.SDA_OUT) sda_low_seen = 1'b1;
      if (bus.tx_req) begin
        txreq_cnt++;
        tx_data_m = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
      end
    end
  end

  task automatic clear_counts();
    rx_got.delete(); exp_rx.delete(); tx_q.delete();
    start_cnt = 0; stop_cnt = 0; txreq_cnt = 0; exp_start = 0; exp_txreq = 0;
    addr_seen = 1'b0; sda_low_seen = 1'b0; exp_addr = 1'b0;
  endtask

  task automatic wclk(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // One SCL period is 16 clk: SDA changes mid-low, line sampled mid-high.
  task automatic bit_out(input logic b);
    scl_m = 1'b0; wclk(4); sda_m = b; wclk(4); scl_m = 1'b1; wclk(8);
  endtask

  task automatic bit_in(output logic b);
    scl_m = 1'b0; wclk(4); sda_m = 1'b1; wclk(4); scl_m = 1'b1; wclk(4);
    b = bus.SDA_IN; wclk(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_n);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(ack_n);
  endtask

  task automatic send_start();
    scl_m = 1'b0; wclk(4); sda_m = 1'b1; wclk(4); scl_m = 1'b1; wclk(8);
    sda_m = 1'b0; wclk(8);
  endtask

  task automatic send_stop();
    scl_m = 1'b0; wclk(4); sda_m = 1'b0; wclk(4); scl_m = 1'b1; wclk(8);
    sda_m = 1'b1; wclk(8);
  endtask

  // START + address + n data bytes from data_a; read bytes are ACKed except the last.
  task automatic txn(input logic [6:0] a, input logic rw, input int n);
    logic       match, ack_n;
    logic [7:0] rb;
    match = (a == ADDR) || (GC_EN && a == 7'd0 && !rw);
    exp_start++;
    if (match) exp_addr = 1'b1;
    if (rw && match) for (int i = 0; i < n; i++) tx_q.push_back(data_a[i]);
    send_start();
    write_byte({a, rw}, ack_n);
    check("addr_ack_n", {31'd0, ack_n}, {31'd0, !match});
    if (!rw) begin
      for (int i = 0; i < n; i++) begin
        write_byte(data_a[i], ack_n);
        check("data_ack_n", {31'd0, ack_n}, {31'd0, !match});
        if (match) exp_rx.push_back({(i == 0), data_a[i]});
      end
    end else if (match) begin
      for (int i = 0; i < n; i++) begin
        read_byte(rb, (i == n - 1));
        check("rd_byte", {24'd0, rb}, {24'd0, data_a[i]});
        exp_txreq++;
      end
    end
  endtask

  task automatic finish_txn();
    send_stop();
    wclk(4);
    check("start_cnt", start_cnt, exp_start);
    check("stop_cnt", stop_cnt, 1);
    check("txreq_cnt", txreq_cnt, exp_txreq);
    check("addressed_seen", {31'd0, addr_seen}, {31'd0, exp_addr});
    check("sda_pulled", {31'd0, sda_low_seen}, {31'd0, exp_addr});
    check("addressed_after_stop", {31'd0, bus.addressed}, 32'd0);
    check("rx_count", rx_got.size(), exp_rx.size());
    for (int i = 0; i < rx_got.size() && i < exp_rx.size(); i++)
      check("rx_byte_first", {23'd0, rx_got[i]}, {23'd0, exp_rx[i]});
    clear_counts();
  endtask

  initial begin
    logic       ack_n;
    logic [6:0] a;
    int         sel;
    clear_counts();
    n_reset = 1'b0; scl_m = 1'b0; sda_m = 1'b0; tx_data_m = 8'h00;
    wclk(3);
    check("rst_sda_out", {31'd0, bus.SDA_OUT}, 32'd1);
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("rst_strobes", {26'd0, bus.rx_valid, bus.rx_first, bus.tx_req,
                          bus.addressed, bus.start_det, bus.stop_det}, 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    wclk(3);
    n_reset = 1'b1;
    wclk(4);
    mon_en = 1'b1;
    clear_counts();

    data_a[0] = 8'h00; data_a[1] = 8'hAF;
    txn(ADDR, 1'b0, 2); finish_txn();

    data_a[0] = 8'h55;
    txn(7'h3D, 1'b0, 1); finish_txn();

    data_a[0] = 8'hA5; data_a[1] = 8'h3C;
    txn(ADDR, 1'b1, 2); finish_txn();

    data_a[0] = 8'h11;
    txn(ADDR, 1'b0, 1);
    data_a[0] = 8'h22;
    txn(ADDR, 1'b0, 1); finish_txn();

    data_a[0] = 8'h06;
    txn(7'h00, 1'b0, 1); finish_txn();

    // Reset while the target is driving the address ACK must release SDA.
    send_start();
    write_byte({ADDR, 1'b0}, ack_n);
    check("mid_rst_ack_n", {31'd0, ack_n}, 32'd0);
    n_reset = 1'b0;
    wclk(1);
    check("mid_rst_sda_out", {31'd0, bus.SDA_OUT}, 32'd1);
    check("mid_rst_addressed", {31'd0, bus.addressed}, 32'd0);
    n_reset = 1'b1;
    wclk(4);
    clear_counts();

    for (int t = 0; t < 20; t++) begin
      sel = $urandom_range(0, 3);
      if (sel <= 1) a = ADDR;
      else if (sel == 2) a = 7'd0;
      else begin
        a = 7'($urandom);
        while (a == ADDR || a == 7'd0) a = 7'($urandom);
      end
      for (int i = 0; i < 4; i++) data_a[i] = 8'($urandom);
      txn(a, 1'($urandom), $urandom_range(1, 3));
      finish_txn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
